serial_twos_decoder: RTL
========================

SERIAL_TWOS_DECODER -- requirements
Module: serial_twos_decoder

Interface
REQ-001 Parameter: WIDTH, 8, number of bits per serial frame (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port: in  input  1  serial two's-complement data, LSB first, one bit per clk.
REQ-005 Port: start  input  1  high in the same cycle as bit 0 of a frame.
REQ-006 Port: out_word  output  WIDTH  decoded word (two's complement of the received frame), registered.
REQ-007 Port: rx_word  output  WIDTH  raw received frame, registered alongside out_word.
REQ-008 Port: valid  output  1  one-cycle pulse: out_word and rx_word hold a new frame.
REQ-009 Port: busy  output  1  high while a frame is partially received.
REQ-010 Port: abort  output  1  one-cycle pulse: the frame in progress was discarded by a new start.

Function
REQ-011 Block SHALL recover the original word from the serial two's-complement stream, bit by bit; it is the receive end of the serial converter.
REQ-012 FSM SHALL have states IDLE, COPY and INVERT.
  - IDLE: no frame in progress.
  - COPY: no 1 seen yet in the frame.
  - INVERT: a 1 has been seen in the frame.
REQ-013 Each accepted bit SHALL decode as follows.
  - Decoded bit d = in XOR seen_one.
  - seen_one = 1 only if an earlier bit of the current frame was 1; bit 0 always uses seen_one = 0.
REQ-014 Transition after each accepted bit:
  - to INVERT if in = 1 or already in INVERT;
  - otherwise to COPY.
REQ-015 The block SHALL accept bits as follows.
  - start = 1 in any state: accept the bit as bit 0.
  - In COPY or INVERT with start = 0: accept the bit as the next bit.
  - In IDLE with start = 0: ignore in.
REQ-016 A 0..WIDTH-1 bit counter SHALL index the accepted bit.
  - d and in SHALL shift into internal registers at position counter, giving LSB-first assembly.
REQ-017 End of frame: on the edge accepting bit WIDTH-1, the block SHALL update out_word/rx_word, pulse valid the next cycle, and return to IDLE.
  - Latency: valid high in the cycle immediately after the cycle carrying the last bit.
REQ-018 out_word and rx_word SHALL hold their values until the next completed frame.
REQ-019 busy SHALL be high in the cycles after bit 0 through bit WIDTH-2 is accepted, and low otherwise.
REQ-020 A start while busy = 1 SHALL have the following effects.
  - Discard the partial frame, with no valid for it.
  - Pulse abort for one cycle.
  - Accept the current bit as bit 0 of a new frame.
REQ-021 Back-to-back frames: a start in the cycle after the last bit (the valid cycle) SHALL be accepted normally, with no abort and no gap.
REQ-022 WIDTH = 8 special cases:
  - stream 0x00 SHALL decode to 0x00;
  - stream 0x80 SHALL decode to 0x80 (most-negative value maps to itself, no flag).
REQ-023 Arithmetic SHALL be bitwise modulo 2^WIDTH; no sign extension and no overflow output.

Reset
REQ-024 reset = 1 SHALL take priority over start and in on the same edge.
REQ-025 Values after reset:
  - state IDLE, counter 0;
  - out_word and rx_word = 0;
  - valid, busy and abort = 0.
REQ-026 Reset mid-frame SHALL discard the partial frame with no valid and no abort pulse.

Verification (WIDTH = 8)
REQ-027 Bench SHALL cover these directed scenarios.
  - Frame 0xA6 (bits 0,1,1,0,0,1,0,1 with start on the first bit) -> valid one cycle after the last bit; out_word = 0x5A, rx_word = 0xA6.
  - Frame 0x01 -> out_word = 0xFF; frame 0x00 -> out_word = 0x00; frame 0x80 -> out_word = 0x80.
  - Two frames 0xA6 then 0xFF, back to back with start in the valid cycle -> two valid pulses 8 cycles apart; out_word 0x5A then 0x01; abort stays 0.
  - start re-asserted on bit 4 of a frame, then 8 bits of 0xA6 -> abort pulses once, no valid for the first frame, then out_word = 0x5A.
  - reset asserted on bit 3 of a frame -> busy = 0 next cycle; no valid; out_word stays at its prior value of 0.
  - Bits driven with start low in IDLE -> no state change; busy, valid and abort stay 0.

Source files
------------

// File: rtl/serial_twos_decoder.sv
// serial_twos_decoder: recovers words from an LSB-first serial two's-complement stream
module serial_twos_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             start,
  output logic [WIDTH-1:0] out_word,
  output logic [WIDTH-1:0] rx_word,
  output logic             valid,
  output logic             busy,
  output logic             abort
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, COPY, INVERT} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt, w_pos;
  logic [WIDTH-1:0] r_dec, r_raw, w_dec, w_raw;
  logic             w_acc, w_seen, w_d, w_last;
  always_comb begin
    w_acc  = start || r_state != IDLE;
    w_seen = !start && r_state == INVERT;
    w_d    = in ^ w_seen;
    w_pos  = start ? '0 : r_cnt;
    w_last = w_acc && w_pos == LAST;
    w_dec  = r_dec;
    w_dec[w_pos] = w_d;
    w_raw  = r_raw;
    w_raw[w_pos] = in;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dec    <= '0;
      r_raw    <= '0;
      out_word <= '0;
      rx_word  <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      valid <= w_last;
      busy  <= w_acc && !w_last;
      abort <= start && r_state != IDLE;
      if (w_acc) begin
        r_dec   <= w_dec;
        r_raw   <= w_raw;
        r_cnt   <= w_last ? '0 : w_pos + 1'b1;
        r_state <= w_last ? IDLE : (in || w_seen) ? INVERT : COPY;
      end
      if (w_last) begin
        out_word <= w_dec;
        rx_word  <= w_raw;
      end
    end
  end
endmodule
